// File: rtl/pong_pkg.sv
// Shared Pong datapath definitions: screen geometry, frame-tick row and ball FSM states.
package pong_pkg;
   localparam int X_MAX    = 639;
   localparam int Y_MAX    = 479;
   localparam int TICK_ROW = 481;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_WAIT,
      PLAY,
      OVER
   } ball_state_t;
endpackage

// File: rtl/ball_engine_if.sv
// Ball engine bus: pixel scan position, serve button and paddle boxes in; ball position, pixel hit, scores out.
interface ball_engine_if;
   logic [9:0] x;
   logic [9:0] y;
   logic       serve;
   logic [9:0] pad1_t, pad1_b, pad1_l, pad1_r;
   logic [9:0] pad2_t, pad2_b, pad2_l, pad2_r;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic       ball_on;
   logic [3:0] score1;
   logic [3:0] score2;
   logic       point1;
   logic       point2;
   logic       game_over;

   modport master (
      output x, y, serve, pad1_t, pad1_b, pad1_l, pad1_r, pad2_t, pad2_b, pad2_l, pad2_r,
      input  ball_x, ball_y, ball_on, score1, score2, point1, point2, game_over
   );
   modport slave (
      input  x, y, serve, pad1_t, pad1_b, pad1_l, pad1_r, pad2_t, pad2_b, pad2_l, pad2_r,
      output ball_x, ball_y, ball_on, score1, score2, point1, point2, game_over
   );
endinterface

// File: rtl/ball_collide.sv
// Combinational collision flags for the current ball position; no state, no latency.
// miss1 = ball got past paddle 1 on the right (player 2 scores), miss2 = past paddle 2 on the left.
module ball_collide
   import pong_pkg::*;
#(
   parameter int BALL_SIZE     = 8,
   parameter int BALL_VELOCITY = 2
) (
   input  logic [9:0] i_ball_x,
   input  logic [9:0] i_ball_y,
   input  logic       i_dx,
   input  logic [3:0] i_vx,
   input  logic [9:0] i_pad1_t, i_pad1_b, i_pad1_l, i_pad1_r,
   input  logic [9:0] i_pad2_t, i_pad2_b, i_pad2_l, i_pad2_r,
   output logic       o_hit1,
   output logic       o_hit2,
   output logic       o_miss1,
   output logic       o_miss2,
   output logic       o_wall_top,
   output logic       o_wall_bot
);
   logic [10:0] w_left, w_right, w_top, w_bot, w_vx;
   logic        w_vert1, w_vert2;

   // Subtractions are moved to the other side of each compare so nothing can wrap.
   assign w_left  = {1'b0, i_ball_x};
   assign w_top   = {1'b0, i_ball_y};
   assign w_right = w_left + 11'(BALL_SIZE - 1);
   assign w_bot   = w_top + 11'(BALL_SIZE - 1);
   assign w_vx    = {7'd0, i_vx};

   assign w_vert1 = (w_bot >= {1'b0, i_pad1_t}) && (w_top <= {1'b0, i_pad1_b});
   assign w_vert2 = (w_bot >= {1'b0, i_pad2_t}) && (w_top <= {1'b0, i_pad2_b});

   assign o_hit1 = i_dx && (w_right + w_vx >= {1'b0, i_pad1_l})
                        && (w_right <= {1'b0, i_pad1_r}) && w_vert1;
   assign o_hit2 = !i_dx && (w_left >= {1'b0, i_pad2_l})
                         && (w_left <= {1'b0, i_pad2_r} + w_vx) && w_vert2;

   assign o_miss1 = i_dx && !o_hit1 && (w_right + w_vx >= 11'(X_MAX));
   assign o_miss2 = !i_dx && !o_hit2 && (w_left <= w_vx);

   assign o_wall_top = (w_top <= 11'(BALL_VELOCITY));
   assign o_wall_bot = (w_bot + 11'(BALL_VELOCITY) >= 11'(Y_MAX));
endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: per-frame motion, bounces, scoring and IDLE/SERVE_WAIT/PLAY/OVER sequencing.
// Build option BALL_SPEEDUP_EN: each paddle hit adds 1 to horizontal speed, capped at MAX_VELOCITY.
module ball_engine
   import pong_pkg::*;
#(
`ifdef BALL_SPEEDUP_EN
   parameter int MAX_VELOCITY  = 5,
`endif
   parameter int BALL_SIZE     = 8,
   parameter int BALL_VELOCITY = 2,
   parameter int SERVE_DELAY   = 60,
   parameter int WIN_SCORE     = 9
) (
   input logic          clk,
   input logic          reset,
   ball_engine_if.slave bus
);
   localparam logic [9:0] CENTER_X = 10'((X_MAX + 1 - BALL_SIZE) / 2);
   localparam logic [9:0] CENTER_Y = 10'((Y_MAX + 1 - BALL_SIZE) / 2);
   localparam int         CNT_W    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

   ball_state_t      r_state;
   logic [9:0]       r_ball_x, r_ball_y;
   logic             r_dx, r_dy;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_score1, r_score2;
   logic             r_point1, r_point2, r_game_over;

   logic       w_tick, w_hit1, w_hit2, w_miss1, w_miss2, w_wall_top, w_wall_bot;
   logic       w_dx_nxt, w_dy_nxt;
   logic [3:0] w_vx, w_vx_nxt;
   logic [9:0] w_step_x, w_x_nxt, w_y_nxt;
   logic [10:0] w_on_xr, w_on_yb;

`ifdef BALL_SPEEDUP_EN
   logic [3:0] r_vx;
   assign w_vx     = r_vx;
   assign w_vx_nxt = ((w_hit1 || w_hit2) && (r_vx < 4'(MAX_VELOCITY))) ? r_vx + 4'd1 : r_vx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_vx <= 4'(BALL_VELOCITY);
      else if (r_state == PLAY && w_tick)
         r_vx <= (w_miss1 || w_miss2) ? 4'(BALL_VELOCITY) : w_vx_nxt;
   end
`else
   assign w_vx     = 4'(BALL_VELOCITY);
   assign w_vx_nxt = w_vx;
`endif

   ball_collide #(
      .BALL_SIZE     (BALL_SIZE),
      .BALL_VELOCITY (BALL_VELOCITY)
   ) u_collide (
      .i_ball_x   (r_ball_x),
      .i_ball_y   (r_ball_y),
      .i_dx       (r_dx),
      .i_vx       (w_vx),
      .i_pad1_t   (bus.pad1_t),
      .i_pad1_b   (bus.pad1_b),
      .i_pad1_l   (bus.pad1_l),
      .i_pad1_r   (bus.pad1_r),
      .i_pad2_t   (bus.pad2_t),
      .i_pad2_b   (bus.pad2_b),
      .i_pad2_l   (bus.pad2_l),
      .i_pad2_r   (bus.pad2_r),
      .o_hit1     (w_hit1),
      .o_hit2     (w_hit2),
      .o_miss1    (w_miss1),
      .o_miss2    (w_miss2),
      .o_wall_top (w_wall_top),
      .o_wall_bot (w_wall_bot)
   );

   assign w_tick   = (bus.y == 10'(TICK_ROW)) && (bus.x == 10'd0);
   assign w_dx_nxt = w_hit1 ? 1'b0 : (w_hit2 ? 1'b1 : r_dx);
   assign w_dy_nxt = w_wall_top ? 1'b1 : (w_wall_bot ? 1'b0 : r_dy);
   assign w_step_x = {6'd0, w_vx_nxt};
   assign w_x_nxt  = w_dx_nxt ? r_ball_x + w_step_x : r_ball_x - w_step_x;
   assign w_y_nxt  = w_dy_nxt ? r_ball_y + 10'(BALL_VELOCITY) : r_ball_y - 10'(BALL_VELOCITY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_ball_x    <= CENTER_X;
         r_ball_y    <= CENTER_Y;
         r_dx        <= 1'b1;
         r_dy        <= 1'b1;
         r_cnt       <= '0;
         r_score1    <= 4'd0;
         r_score2    <= 4'd0;
         r_point1    <= 1'b0;
         r_point2    <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_point1 <= 1'b0;
         r_point2 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.serve) begin
                  r_state <= SERVE_WAIT;
                  r_cnt   <= '0;
               end
            end
            SERVE_WAIT: begin
               if (w_tick) begin
                  if (r_cnt == CNT_W'(SERVE_DELAY - 1)) begin
                     r_state <= PLAY;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            PLAY: begin
               if (w_tick && (w_miss1 || w_miss2)) begin
                  // Ball recentres and heads toward the player who conceded; dy is kept.
                  r_ball_x <= CENTER_X;
                  r_ball_y <= CENTER_Y;
                  r_cnt    <= '0;
                  if (w_miss1) begin
                     r_dx     <= 1'b1;
                     r_score2 <= r_score2 + 4'd1;
                     r_point2 <= 1'b1;
                  end else begin
                     r_dx     <= 1'b0;
                     r_score1 <= r_score1 + 4'd1;
                     r_point1 <= 1'b1;
                  end
                  if ((w_miss1 && r_score2 == 4'(WIN_SCORE - 1)) ||
                      (w_miss2 && r_score1 == 4'(WIN_SCORE - 1))) begin
                     r_state     <= OVER;
                     r_game_over <= 1'b1;
                  end else begin
                     r_state <= SERVE_WAIT;
                  end
               end else if (w_tick) begin
                  r_ball_x <= w_x_nxt;
                  r_ball_y <= w_y_nxt;
                  r_dx     <= w_dx_nxt;
                  r_dy     <= w_dy_nxt;
               end
            end
            OVER: begin
               if (bus.serve) begin
                  r_state     <= SERVE_WAIT;
                  r_cnt       <= '0;
                  r_score1    <= 4'd0;
                  r_score2    <= 4'd0;
                  r_game_over <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_on_xr     = {1'b0, r_ball_x} + 11'(BALL_SIZE - 1);
   assign w_on_yb     = {1'b0, r_ball_y} + 11'(BALL_SIZE - 1);
   assign bus.ball_on = (bus.x >= r_ball_x) && ({1'b0, bus.x} <= w_on_xr) &&
                        (bus.y >= r_ball_y) && ({1'b0, bus.y} <= w_on_yb);

   assign bus.ball_x    = r_ball_x;
   assign bus.ball_y    = r_ball_y;
   assign bus.score1    = r_score1;
   assign bus.score2    = r_score2;
   assign bus.point1    = r_point1;
   assign bus.point2    = r_point2;
   assign bus.game_over = r_game_over;
endmodule

// File: tb/tb_ball_engine.sv
// Randomised bench for ball_engine: pixel positions and frame ticks driven directly, every
// clock compared against a frame-level game model kept in plain integers.
module tb_ball_engine;
   localparam int SD  = 2;
   localparam int WIN = 2;
   localparam int V   = 2;
   localparam int SZ  = 8;
   localparam int CX  = 316;
   localparam int CY  = 236;
   localparam int M_IDLE = 0, M_WAIT = 1, M_PLAY = 2, M_OVER = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   ball_engine_if bus();

   ball_engine #(.SERVE_DELAY(SD), .WIN_SCORE(WIN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   int m_st, m_bx, m_by, m_dx, m_dy, m_cnt, m_s1, m_s2, m_p1, m_p2;
   int p1t, p1b, p1l, p1r, p2t, p2b, p2l, p2r;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_pads(input int a, b, c, d, e, f, g, h);
      p1t = a; p1b = b; p1l = c; p1r = d;
      p2t = e; p2b = f; p2l = g; p2r = h;
      bus.pad1_t = 10'(a); bus.pad1_b = 10'(b); bus.pad1_l = 10'(c); bus.pad1_r = 10'(d);
      bus.pad2_t = 10'(e); bus.pad2_b = 10'(f); bus.pad2_l = 10'(g); bus.pad2_r = 10'(h);
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_bx = CX; m_by = CY; m_dx = 1; m_dy = 1;
      m_cnt = 0; m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;
   endtask

   task automatic model_play_tick();
      int r, b;
      bit v1, v2, h1, h2, mr, ml;
      r  = m_bx + SZ - 1;
      b  = m_by + SZ - 1;
      v1 = (b >= p1t) && (m_by <= p1b);
      v2 = (b >= p2t) && (m_by <= p2b);
      h1 = (m_dx == 1) && (r >= p1l - V) && (r <= p1r) && v1;
      h2 = (m_dx == 0) && (m_bx >= p2l) && (m_bx <= p2r + V) && v2;
      mr = !h1 && (m_dx == 1) && (r >= 639 - V);
      ml = !h2 && (m_dx == 0) && (m_bx <= V);
      if (mr || ml) begin
         if (mr) begin m_s2++; m_p2 = 1; m_dx = 1; end
         else    begin m_s1++; m_p1 = 1; m_dx = 0; end
         m_bx = CX; m_by = CY; m_cnt = 0;
         m_st = (m_s1 == WIN || m_s2 == WIN) ? M_OVER : M_WAIT;
      end else begin
         if (h1) m_dx = 0;
         if (h2) m_dx = 1;
         if (m_by <= V) m_dy = 1;
         else if (b >= 479 - V) m_dy = 0;
         m_bx = m_bx + ((m_dx == 1) ? V : -V);
         m_by = m_by + ((m_dy == 1) ? V : -V);
      end
   endtask

   task automatic model_clk(input int xi, input int yi, input bit sv);
      bit tk;
      tk = (yi == 481) && (xi == 0);
      m_p1 = 0; m_p2 = 0;
      if (m_st == M_IDLE && sv) begin
         m_st = M_WAIT; m_cnt = 0;
      end else if (m_st == M_WAIT && tk) begin
         m_cnt++;
         if (m_cnt == SD) m_st = M_PLAY;
      end else if (m_st == M_PLAY && tk) begin
         model_play_tick();
      end else if (m_st == M_OVER && sv) begin
         m_s1 = 0; m_s2 = 0; m_cnt = 0; m_st = M_WAIT;
      end
   endtask

   task automatic check_regs();
      check("ball_x",    32'(bus.ball_x),    m_bx);
      check("ball_y",    32'(bus.ball_y),    m_by);
      check("score1",    32'(bus.score1),    m_s1);
      check("score2",    32'(bus.score2),    m_s2);
      check("point1",    32'(bus.point1),    m_p1);
      check("point2",    32'(bus.point2),    m_p2);
      check("game_over", 32'(bus.game_over), (m_st == M_OVER) ? 1 : 0);
   endtask

   task automatic step(input int xi, input int yi, input bit sv);
      bit on;
      bus.x = 10'(xi); bus.y = 10'(yi); bus.serve = sv;
      #1;
      on = (xi >= m_bx) && (xi <= m_bx + SZ - 1) && (yi >= m_by) && (yi <= m_by + SZ - 1);
      check("ball_on", 32'(bus.ball_on), 32'(on));
      @(posedge clk);
      model_clk(xi, yi, sv);
      #1;
      check_regs();
      @(negedge clk);
   endtask

   task automatic frame(input bit rnd_serve);
      int n;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
         int xi, yi;
         if ($urandom_range(0, 1) == 1) begin
            xi = m_bx - 1 + int'($urandom_range(0, 9));
            yi = m_by - 1 + int'($urandom_range(0, 9));
         end else begin
            xi = int'($urandom_range(0, 799));
            yi = int'($urandom_range(0, 524));
         end
         if (xi == 0 && yi == 481) yi = 480;
         step(xi, yi, rnd_serve ? bit'($urandom_range(0, 1)) : 1'b0);
      end
      step(0, 481, rnd_serve ? bit'($urandom_range(0, 1)) : 1'b0);
   endtask

   initial begin
      int prev_x;
      int guard;
      set_pads(0, 479, 600, 603, 0, 479, 20, 23);
      bus.x = 10'd0; bus.y = 10'd0; bus.serve = 1'b0;
      model_reset();
      #1 reset = 1'b0;
      #2;
      check("rst_ball_x", 32'(bus.ball_x), CX);
      check("rst_ball_y", 32'(bus.ball_y), CY);
      check("rst_score1", 32'(bus.score1), 0);
      check("rst_game_over", 32'(bus.game_over), 0);
      @(negedge clk);
      reset = 1'b1;

      // No serve: ten frames with the ball parked at centre.
      for (int i = 0; i < 10; i++) frame(1'b0);
      check("idle_ball_x", 32'(bus.ball_x), CX);
      check("idle_score2", 32'(bus.score2), 0);

      // Serve: two ticks of delay, motion on the third.
      step(5, 5, 1'b1);
      frame(1'b0);
      frame(1'b0);
      check("serve_wait_x", 32'(bus.ball_x), CX);
      frame(1'b0);
      check("first_move_x", 32'(bus.ball_x), 318);
      check("first_move_y", 32'(bus.ball_y), 238);

      // Full-height paddles: rally with wall and paddle bounces, serve noise ignored.
      prev_x = int'(bus.ball_x);
      for (int i = 0; i < 300; i++) begin
         frame(1'b1);
         if (prev_x == 592) check("pad1_bounce_x", 32'(bus.ball_x), 590);
         prev_x = int'(bus.ball_x);
      end

      // Short paddle 1: player 2 scores until the game ends.
      set_pads(0, 10, 600, 603, 0, 479, 20, 23);
      guard = 0;
      while (m_st != M_OVER && guard < 3000) begin
         frame(1'b0);
         guard++;
      end
      check("over_game_over", 32'(bus.game_over), 1);
      check("over_score2", 32'(bus.score2), WIN);
      for (int i = 0; i < 5; i++) frame(1'b0);
      check("over_frozen_x", 32'(bus.ball_x), CX);

      // Serve from OVER clears scores; then short paddle 2 lets player 1 score.
      step(7, 7, 1'b1);
      check("reserve_score2", 32'(bus.score2), 0);
      check("reserve_game_over", 32'(bus.game_over), 0);
      set_pads(0, 479, 600, 603, 0, 10, 20, 23);
      guard = 0;
      while (m_s1 < 1 && guard < 2000) begin
         frame(1'b1);
         guard++;
      end
      check("left_miss_score1", 32'(bus.score1), 1);
      for (int i = 0; i < 40; i++) frame(1'b1);

      // Asynchronous reset mid-play, away from any clock edge.
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("arst_ball_x", 32'(bus.ball_x), CX);
      check("arst_ball_y", 32'(bus.ball_y), CY);
      check("arst_score1", 32'(bus.score1), 0);
      check("arst_point1", 32'(bus.point1), 0);
      check("arst_game_over", 32'(bus.game_over), 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) frame(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
